conv_encoder_tx: RTL
====================

// Module: conv_encoder_tx
// PURPOSE
//   Rate-1/2, K=3 (4-state) convolutional encoder feeding the Viterbi decoder path.
//   Accepts one info bit per valid/ready handshake and emits one 2-bit code symbol
//   per downstream handshake. Frames are delimited by in_last. Optional zero-tail
//   termination drives the trellis back to state 00 at end of frame.
// PARAMETERS
//   G0     3'b111  generator for out_sym[1]; bit2 taps input, bit1 taps s[1], bit0 taps s[0]
//   G1     3'b101  generator for out_sym[0]; same tap ordering
//   CNT_W  8       width of sym_count
// PORTS
//   clk        in   1      single clock; all state changes on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   in_valid   in   1      in_bit/in_last valid
//   in_ready   out  1      encoder accepts input this cycle
//   in_bit     in   1      information bit
//   in_last    in   1      marks the final info bit of the frame
//   out_valid  out  1      out_sym valid
//   out_ready  in   1      downstream accepts the symbol
//   out_sym    out  2      {G0 parity, G1 parity}
//   out_last   out  1      final symbol of frame (last tail symbol, or last data symbol)
//   enc_state  out  2      current shift register s[1:0]; s[1] is the newest bit
//   sym_count  out  CNT_W  symbols emitted in current frame; saturates at all-ones
// BEHAVIOUR
//   - Reset: out_valid=0, out_sym=00, out_last=0, enc_state=00, sym_count=0, FSM=ENC.
//   - Encoding: r={u,s[1],s[0]}; out_sym[1]=^(r&G0); out_sym[0]=^(r&G1); next s={u,s[1]}.
//   - Output register is a single stage. The symbol appears at out_valid one cycle after
//     the input handshake. Full throughput: in_ready = (FSM==ENC) && (!out_valid || out_ready).
//   - Backpressure: while out_valid && !out_ready, out_sym, out_last and enc_state hold stable.
//   - FSM: ENC -> (accept with in_last) -> TAIL1 -> TAIL2 -> ENC.
//     A TAIL state injects u=0 internally when the output slot is free
//     (!out_valid || out_ready). in_ready=0 in TAIL states.
//   - After TAIL2 the state is 00 by construction. out_last is set on the TAIL2 symbol.
//   - Simultaneous events: in the cycle a symbol drains and a new bit or tail is loaded,
//     out_valid stays 1 with the new symbol. There is no bubble.
//   - sym_count increments on each out handshake. It clears to 0 in the same cycle that the
//     out_last symbol is handshaken. It saturates and does not wrap.
//   - in_bit/in_last are ignored when in_valid=0. No handshake occurs when in_ready=0.
//   - An rst_n assertion mid-frame aborts the frame immediately. All outputs return to their
//     reset values. A pending symbol is discarded.
// CONFIGURATION
//   CONV_ENC_TAIL_EN defined: zero-tail termination as above. Each frame of N bits
//     yields N+2 symbols, and the frame ends in state 00.
//   CONV_ENC_TAIL_EN undefined: TAIL1/TAIL2 are removed. out_last is set on the symbol
//     of the in_last bit. enc_state resets to 00 on acceptance of in_last, so each frame
//     starts in 00. The frame ends unterminated (N symbols), and the decoder picks its
//     traceback start via its min-state search.
// TESTING
//   1. Reset: hold rst_n=0 with random inputs -> out_valid=0, enc_state=00, sym_count=0.
//   2. Tail on, bits 1,0,1,1(last), out_ready=1 -> out_sym 11,10,00,01,01,11; out_last
//      only on the 6th symbol; enc_state=00 after.
//   3. Tail off, same stimulus -> out_sym 11,10,00,01; out_last on the 4th symbol;
//      enc_state=00 after the last accept.
//   4. Backpressure: out_ready=0 for 3 cycles mid-frame -> in_ready=0 and out_sym held;
//      on release the stream resumes with no loss or duplication.
//   5. Async reset pulse during TAIL1 -> outputs clear without waiting for clk; the next
//      frame starts from state 00 with sym_count=0.
//   6. CNT_W=2, 6-bit frame -> sym_count saturates at 3 and clears on the out_last handshake.

Source files
------------

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
//   Rate-1/2, K=3 convolutional encoder with valid/ready handshakes on both sides.
//   Takes one information bit per input handshake and emits one 2-bit code symbol
//   per output handshake through a single registered output stage. Frames are
//   delimited by in_last.
//
//   Build option CONV_ENC_TAIL_EN:
//     defined   - two zero tail symbols (TAIL1, TAIL2) follow each frame so the
//                 trellis ends in state 00; out_last marks the second tail symbol.
//     undefined - no tail; out_last marks the symbol of the in_last bit and the
//                 shift register is cleared when that bit is accepted.
//
// Parameters
//   G0, G1   generator taps {input, s[1], s[0]} for out_sym[1] / out_sym[0]
//   CNT_W    width of sym_count
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_bit, in_last qualified by in_valid
//   out_valid/out_ready   output handshake; out_sym = {G0 parity, G1 parity}
//   out_last              final symbol of the frame
//   enc_state             shift register s[1:0], s[1] newest bit
//   sym_count             symbols handshaken in this frame, saturating
module conv_encoder_tx #(
  parameter logic [2:0]  G0    = 3'b111,
  parameter logic [2:0]  G1    = 3'b101,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sym,
  output logic             out_last,
  output logic [1:0]       enc_state,
  output logic [CNT_W-1:0] sym_count
);

  // Output register can take a new symbol when empty or draining this cycle.
  logic       slot_free;
  logic       load;
  logic       u;
  logic       last_nxt;
  logic [1:0] state_nxt;
  logic [2:0] r;
  logic [1:0] sym_nxt;

  assign slot_free = !out_valid || out_ready;

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic [1:0] {ENC, TAIL1, TAIL2} fsm_t;

  fsm_t fsm, fsm_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= ENC;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    load     = 1'b0;
    u        = 1'b0;
    last_nxt = 1'b0;
    case (fsm)
      ENC: begin
        in_ready = slot_free;
        load     = in_valid && slot_free;
        u        = in_bit;
        if (load && in_last) begin
          fsm_nxt = TAIL1;
        end
      end
      TAIL1: begin
        load = slot_free;
        if (slot_free) begin
          fsm_nxt = TAIL2;
        end
      end
      TAIL2: begin
        load     = slot_free;
        last_nxt = 1'b1;
        if (slot_free) begin
          fsm_nxt = ENC;
        end
      end
      default: fsm_nxt = ENC;
    endcase
    state_nxt = {u, enc_state[1]};
  end
`else
  always_comb begin
    in_ready  = slot_free;
    load      = in_valid && slot_free;
    u         = in_bit;
    last_nxt  = in_last;
    // Clearing on the last bit makes every frame start from state 00.
    state_nxt = in_last ? 2'b00 : {u, enc_state[1]};
  end
`endif

  always_comb begin
    r       = {u, enc_state};
    sym_nxt = {^(r & G0), ^(r & G1)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
      enc_state <= 2'b00;
      sym_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_sym   <= sym_nxt;
        out_last  <= last_nxt;
        enc_state <= state_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (out_valid && out_ready) begin
        if (out_last) begin
          sym_count <= '0;
        end else if (sym_count != '1) begin
          sym_count <= sym_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
